fwd_hazard_ctrl: RTL and testbench

- Generates the 2-bit select codes for the two EX-stage operand 4:1 muxes (ALU source A and B) of the 5-stage pipelined CPU, plus the load-use stall.
- Keeps its own shadow pipeline of destination-register and control bits for ID/EX and EX/MEM, advanced on the same edges as the datapath pipeline registers.
- Select outputs are registered, so they are valid for the whole EX cycle of the instruction they belong to.

---
 rtl/fwd_hazard_ctrl.sv | 65 ++++++
 tb/tb_fwd_hazard_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX-stage operand forwarding selects and load-use stall,
// driven from a shadow copy of the ID/EX and EX/MEM destination/control bits.
module fwd_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int SEL_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             flush_i,
  output logic [SEL_W-1:0] fwdA_sel_o,
  output logic [SEL_W-1:0] fwdB_sel_o,
  output logic             stall_o
);
  localparam logic [SEL_W-1:0] SEL_RF  = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_EXM = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_MWB = SEL_W'(2);
  logic [REG_W-1:0] ex_rd_q, ex_rd_d, mem_rd_q;
  logic             ex_regwrite_q, ex_regwrite_d, ex_memread_q, ex_memread_d, mem_regwrite_q;
  logic [SEL_W-1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic             bubble, ex_live, mem_live;
  // Register 0 is hard-wired, so a producer targeting it never forwards.
  assign ex_live  = ex_regwrite_q & (ex_rd_q != '0);
  assign mem_live = mem_regwrite_q & (mem_rd_q != '0);
  assign stall_o  = id_valid_i & ex_memread_q & (ex_rd_q != '0) &
                    ((ex_rd_q == id_rs_i) | (ex_rd_q == id_rt_i));
  assign bubble   = flush_i | stall_o | ~id_valid_i;
  always_comb begin
    ex_rd_d       = bubble ? '0 : id_rd_i;
    ex_regwrite_d = ~bubble & id_regwrite_i;
    ex_memread_d  = ~bubble & id_memread_i;
    fwd_a_d       = bubble ? SEL_RF :
                    (ex_live & (ex_rd_q == id_rs_i))   ? SEL_EXM :
                    (mem_live & (mem_rd_q == id_rs_i)) ? SEL_MWB : SEL_RF;
    fwd_b_d       = bubble ? SEL_RF :
                    (ex_live & (ex_rd_q == id_rt_i))   ? SEL_EXM :
                    (mem_live & (mem_rd_q == id_rt_i)) ? SEL_MWB : SEL_RF;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_rd_q        <= '0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      mem_rd_q       <= '0;
      mem_regwrite_q <= 1'b0;
      fwd_a_q        <= SEL_RF;
      fwd_b_q        <= SEL_RF;
    end else begin
      ex_rd_q        <= ex_rd_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memread_q   <= ex_memread_d;
      mem_rd_q       <= ex_rd_q;
      mem_regwrite_q <= ex_regwrite_q;
      fwd_a_q        <= fwd_a_d;
      fwd_b_q        <= fwd_b_d;
    end
  end
  assign fwdA_sel_o = fwd_a_q;
  assign fwdB_sel_o = fwd_b_q;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: table-driven instruction stream plus hand-written reset sequences.
module tb_fwd_hazard_ctrl;
  logic       clk_i = 1'b0, rst_i = 1'b0;
  logic       id_valid_i = 1'b0, id_regwrite_i = 1'b0, id_memread_i = 1'b0, flush_i = 1'b0;
  logic [4:0] id_rs_i = '0, id_rt_i = '0, id_rd_i = '0;
  logic [1:0] fwdA_sel_o, fwdB_sel_o;
  logic       stall_o;
  int         total = 0, bad = 0;

  typedef struct packed {
    logic       v;
    logic [4:0] rs, rt, rd;
    logic       rw, mr, fl, stall;
    logic [1:0] a, b;
  } vec_t;
  vec_t tbl [19];

  fwd_hazard_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i),
    .id_rt_i(id_rt_i), .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i),
    .id_memread_i(id_memread_i), .flush_i(flush_i), .fwdA_sel_o(fwdA_sel_o),
    .fwdB_sel_o(fwdB_sel_o), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  always @(fwdA_sel_o or fwdB_sel_o) begin
    total++;
    if (fwdA_sel_o == 2'b11 || fwdB_sel_o == 2'b11) begin
      bad++;
      $display("FAIL sel_reserved got A=%0h B=%0h want neither 3", fwdA_sel_o, fwdB_sel_o);
    end
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input int rs, input int rt, input int rd,
                              input logic rw, input logic mr, input logic fl,
                              input logic st, input logic [1:0] a, input logic [1:0] b);
    vec_t r;
    r.v = v; r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd);
    r.rw = rw; r.mr = mr; r.fl = fl; r.stall = st; r.a = a; r.b = b;
    return r;
  endfunction

  task automatic drive(input vec_t r);
    id_valid_i = r.v; id_rs_i = r.rs; id_rt_i = r.rt; id_rd_i = r.rd;
    id_regwrite_i = r.rw; id_memread_i = r.mr; flush_i = r.fl;
  endtask

  initial begin
    //            v  rs rt rd  rw mr fl st  A      B
    tbl[0]  = mk(1, 1, 2, 3,  1, 0, 0, 0, 2'd0, 2'd0);
    tbl[1]  = mk(1, 3, 3, 6,  1, 0, 0, 0, 2'd1, 2'd1);
    tbl[2]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 2'd0, 2'd0);
    tbl[3]  = mk(1, 6, 1, 7,  1, 0, 0, 0, 2'd2, 2'd0);
    tbl[4]  = mk(1, 0, 0, 8,  1, 0, 0, 0, 2'd0, 2'd0);
    tbl[5]  = mk(1, 0, 0, 8,  1, 0, 0, 0, 2'd0, 2'd0);
    tbl[6]  = mk(1, 8, 7, 9,  1, 0, 0, 0, 2'd1, 2'd0);
    tbl[7]  = mk(1, 1, 5, 5,  1, 1, 0, 0, 2'd0, 2'd0);
    tbl[8]  = mk(1, 1, 5, 10, 1, 0, 0, 1, 2'd0, 2'd0);
    tbl[9]  = mk(1, 1, 5, 10, 1, 0, 0, 0, 2'd0, 2'd2);
    tbl[10] = mk(1, 1, 2, 0,  1, 0, 0, 0, 2'd0, 2'd0);
    tbl[11] = mk(1, 0, 0, 11, 1, 0, 0, 0, 2'd0, 2'd0);
    tbl[12] = mk(1, 1, 0, 0,  1, 1, 0, 0, 2'd0, 2'd0);
    tbl[13] = mk(1, 0, 0, 12, 1, 0, 0, 0, 2'd0, 2'd0);
    tbl[14] = mk(1, 1, 2, 4,  1, 0, 1, 0, 2'd0, 2'd0);
    tbl[15] = mk(1, 4, 12, 13, 1, 0, 0, 0, 2'd0, 2'd2);
    tbl[16] = mk(1, 1, 2, 5,  1, 1, 0, 0, 2'd0, 2'd0);
    tbl[17] = mk(1, 5, 13, 14, 1, 0, 1, 1, 2'd0, 2'd0);
    tbl[18] = mk(0, 0, 0, 0,  0, 0, 0, 0, 2'd0, 2'd0);

    // Reset held with inputs that would otherwise forward and stall.
    drive(mk(1, 3, 3, 3, 1, 1, 0, 0, 2'd0, 2'd0));
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_hold_a", {2'b0, fwdA_sel_o}, 4'd0);
    chk("rst_hold_b", {2'b0, fwdB_sel_o}, 4'd0);
    chk("rst_hold_stall", {3'b0, stall_o}, 4'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    for (int i = 0; i < 19; i++) begin
      if (i != 0) @(negedge clk_i);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d_stall", i), {3'b0, stall_o}, {3'b0, tbl[i].stall});
      @(posedge clk_i);
      #1;
      chk($sformatf("v%0d_selA", i), {2'b0, fwdA_sel_o}, {2'b0, tbl[i].a});
      chk($sformatf("v%0d_selB", i), {2'b0, fwdB_sel_o}, {2'b0, tbl[i].b});
    end

    // Async reset while a load-use stall is pending and fwdA holds 01.
    @(negedge clk_i);
    drive(mk(1, 1, 2, 6, 1, 0, 0, 0, 2'd0, 2'd0));
    @(negedge clk_i);
    drive(mk(1, 6, 2, 5, 1, 1, 0, 0, 2'd0, 2'd0));
    @(negedge clk_i);
    drive(mk(1, 5, 1, 9, 1, 0, 0, 0, 2'd0, 2'd0));
    #1;
    chk("mid_pre_stall", {3'b0, stall_o}, 4'd1);
    chk("mid_pre_selA", {2'b0, fwdA_sel_o}, 4'd1);
    #1;
    rst_i = 1'b0;
    #1;
    chk("mid_rst_stall", {3'b0, stall_o}, 4'd0);
    chk("mid_rst_selA", {2'b0, fwdA_sel_o}, 4'd0);
    chk("mid_rst_selB", {2'b0, fwdB_sel_o}, 4'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(mk(1, 5, 6, 9, 1, 0, 0, 0, 2'd0, 2'd0));
    #1;
    chk("post_rst_stall", {3'b0, stall_o}, 4'd0);
    @(posedge clk_i);
    #1;
    chk("post_rst_selA", {2'b0, fwdA_sel_o}, 4'd0);
    chk("post_rst_selB", {2'b0, fwdB_sel_o}, 4'd0);
    @(negedge clk_i);
    drive(mk(1, 9, 9, 1, 1, 0, 0, 0, 2'd0, 2'd0));
    @(posedge clk_i);
    #1;
    chk("post_rst_fwdA", {2'b0, fwdA_sel_o}, 4'd1);
    chk("post_rst_fwdB", {2'b0, fwdB_sel_o}, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
